// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_pkg                                                            |
// | Shared encodings, FSM state type and segment type for the snake body.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package snake_pkg;

  localparam logic [1:0] MS_START = 2'd0;
  localparam logic [1:0] MS_PLAY  = 2'd1;
  localparam logic [1:0] MS_WIN   = 2'd2;
  localparam logic [1:0] MS_LOSE  = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Coordinates are held zero-extended so one segment type serves any grid size.
  localparam int SEG_COORD_W = 16;

  typedef struct packed {
    logic [SEG_COORD_W-1:0] x;
    logic [SEG_COORD_W-1:0] y;
  } seg_t;

  function automatic seg_t mk_seg(input logic [SEG_COORD_W-1:0] x,
                                  input logic [SEG_COORD_W-1:0] y);
    seg_t s;
    s.x = x;
    s.y = y;
    return s;
  endfunction

  // UP/DOWN and RIGHT/LEFT differ only in bit 1 of their encodings.
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_next_head.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_next_head                                                      |
// | Combinational next head coordinate with edge wrap / wall detection.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module snake_next_head
  import snake_pkg::*;
#(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int GRID_W    = 160,
  parameter int GRID_H    = 120,
  parameter int WRAP_MODE = 1
) (
  input  logic [X_BITS-1:0] i_x,
  input  logic [Y_BITS-1:0] i_y,
  input  logic [1:0]        i_dir,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_wall
);

  localparam logic [X_BITS-1:0] C_X_MAX      = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] C_Y_MAX      = Y_BITS'(GRID_H - 1);
  localparam logic [X_BITS-1:0] C_X_ONE      = X_BITS'(1);
  localparam logic [Y_BITS-1:0] C_Y_ONE      = Y_BITS'(1);
  localparam logic              C_WALL_KILLS = (WRAP_MODE == 0);

  // o_wall flags an edge crossing only when wrapping is disabled.
  always_comb begin
    o_x    = i_x;
    o_y    = i_y;
    o_wall = 1'b0;
    case (i_dir)
      DIR_UP: begin
        if (i_y == '0) begin
          o_y    = C_Y_MAX;
          o_wall = C_WALL_KILLS;
        end else begin
          o_y = i_y - C_Y_ONE;
        end
      end
      DIR_RIGHT: begin
        if (i_x == C_X_MAX) begin
          o_x    = '0;
          o_wall = C_WALL_KILLS;
        end else begin
          o_x = i_x + C_X_ONE;
        end
      end
      DIR_DOWN: begin
        if (i_y == C_Y_MAX) begin
          o_y    = '0;
          o_wall = C_WALL_KILLS;
        end else begin
          o_y = i_y + C_Y_ONE;
        end
      end
      DIR_LEFT: begin
        if (i_x == '0) begin
          o_x    = C_X_MAX;
          o_wall = C_WALL_KILLS;
        end else begin
          o_x = i_x - C_X_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/snake_body_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_body_engine                                                    |
// | Snake segment array: movement, growth, self/wall collision, pixel    |
// | query. Optional debug port enabled by macro SNAKE_BODY_DEBUG_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int INIT_LEN  = 4,
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int GRID_W    = 160,
  parameter int GRID_H    = 120,
  parameter int WRAP_MODE = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         GAMECLOCK,
  input  logic [1:0]                   MASTER_STATE,
  input  logic [1:0]                   NAVIGATION_STATE,
  input  logic [X_BITS-1:0]            RAND_ADDRH,
  input  logic [Y_BITS-1:0]            RAND_ADDRV,
  input  logic [X_BITS-1:0]            PIX_ADDRH,
  input  logic [Y_BITS-1:0]            PIX_ADDRV,
  output logic                         PIX_BODY,
  output logic                         PIX_HEAD,
  output logic                         REACHED_TARGET,
  output logic                         SUICIDE,
  output logic [$clog2(MAX_LEN+1)-1:0] LENGTH,
  output logic [7:0]                   DEBUG_OUT
);

  localparam int              LEN_W      = $clog2(MAX_LEN + 1);
  localparam int              IDX_W      = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] C_INIT_LEN = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_LEN_ONE  = LEN_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  state_t             r_state;
  logic [1:0]         r_dir;
  seg_t               r_seg [MAX_LEN];
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx;
  logic               r_reached;
  logic               r_suicide;
  logic               r_pix_body;
  logic               r_pix_head;

  logic [1:0]         w_dir;
  logic [X_BITS-1:0]  w_nx;
  logic [Y_BITS-1:0]  w_ny;
  logic               w_wall;
  seg_t               w_next;
  seg_t               w_query;
  logic               w_eat;
  logic               w_frozen;
  logic [MAX_LEN-1:0] w_hit;

  function automatic seg_t init_seg(input int i);
    if (i < INIT_LEN) begin
      return mk_seg(SEG_COORD_W'(GRID_W / 2 - i), SEG_COORD_W'(GRID_H / 2));
    end
    return '0;
  endfunction

  assign w_dir    = is_opposite(NAVIGATION_STATE, r_dir) ? r_dir : NAVIGATION_STATE;
  assign w_next   = mk_seg(SEG_COORD_W'(w_nx), SEG_COORD_W'(w_ny));
  assign w_eat    = (w_next == mk_seg(SEG_COORD_W'(RAND_ADDRH), SEG_COORD_W'(RAND_ADDRV)));
  assign w_query  = mk_seg(SEG_COORD_W'(PIX_ADDRH), SEG_COORD_W'(PIX_ADDRV));
  assign w_frozen = (MASTER_STATE == MS_WIN) || (MASTER_STATE == MS_LOSE);

  snake_next_head #(
    .X_BITS   (X_BITS),
    .Y_BITS   (Y_BITS),
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .WRAP_MODE(WRAP_MODE)
  ) u_next_head (
    .i_x   (r_seg[0].x[X_BITS-1:0]),
    .i_y   (r_seg[0].y[Y_BITS-1:0]),
    .i_dir (w_dir),
    .o_x   (w_nx),
    .o_y   (w_ny),
    .o_wall(w_wall)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_RIGHT;
      r_len     <= C_INIT_LEN;
      r_idx     <= C_IDX_ONE;
      r_reached <= 1'b0;
      r_suicide <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_seg[i] <= init_seg(i);
    end else begin
      r_reached <= 1'b0;
      if (MASTER_STATE == MS_START) begin
        r_state   <= ST_IDLE;
        r_dir     <= DIR_RIGHT;
        r_len     <= C_INIT_LEN;
        r_idx     <= C_IDX_ONE;
        r_suicide <= 1'b0;
        for (int i = 0; i < MAX_LEN; i++) r_seg[i] <= init_seg(i);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (MASTER_STATE == MS_PLAY) r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!w_frozen && GAMECLOCK) begin
              r_dir <= w_dir;
              if (w_wall) begin
                r_suicide <= 1'b1;
                r_state   <= ST_DEAD;
              end else begin
                r_seg[0] <= w_next;
                for (int i = 1; i < MAX_LEN; i++) r_seg[i] <= r_seg[i-1];
                if (w_eat) begin
                  r_reached <= 1'b1;
                  if (r_len != C_MAX_LEN) r_len <= r_len + C_LEN_ONE;
                end
                r_idx   <= C_IDX_ONE;
                r_state <= ST_SCAN;
              end
            end
          end
          ST_SCAN: begin
            if (!w_frozen) begin
              if (r_seg[r_idx] == r_seg[0]) begin
                r_suicide <= 1'b1;
                r_state   <= ST_DEAD;
              end else if (LEN_W'(r_idx) == r_len - C_LEN_ONE) begin
                r_state <= ST_WAIT;
              end else begin
                r_idx <= r_idx + C_IDX_ONE;
              end
            end
          end
          ST_DEAD: ;
          default: ;
        endcase
      end
    end
  end

  // Segments at or beyond the current length are stale and must not match.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_hit
    assign w_hit[i] = (LEN_W'(i) < r_len) && (r_seg[i] == w_query);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pix_body <= 1'b0;
      r_pix_head <= 1'b0;
    end else begin
      r_pix_body <= |w_hit;
      r_pix_head <= w_hit[0];
    end
  end

`ifdef SNAKE_BODY_DEBUG_EN
  logic [7:0] r_debug;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_debug <= 8'h00;
    end else begin
      r_debug <= {r_state, r_dir, 4'(r_len)};
    end
  end

  assign DEBUG_OUT = r_debug;
`else
  assign DEBUG_OUT = 8'h00;
`endif

  assign PIX_BODY       = r_pix_body;
  assign PIX_HEAD       = r_pix_head;
  assign REACHED_TARGET = r_reached;
  assign SUICIDE        = r_suicide;
  assign LENGTH         = r_len;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_snake_body_engine                                                 |
// | Self-checking bench: wrapping and walled instances vs a queue model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_snake_body_engine;

  localparam int GW = 160;
  localparam int GH = 120;
  localparam int ML = 32;
  localparam int IL = 4;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [1:0]    ms;
  logic [1:0]    nav;
  logic [7:0]    th;
  logic [6:0]    tv;
  logic [7:0]    ph;
  logic [6:0]    pv;
  logic          body, head, reached, suicide;
  logic [LW-1:0] len;
  logic [7:0]    dbg;
  logic          body_nw, head_nw, reached_nw, suicide_nw;
  logic [LW-1:0] len_nw;
  logic [7:0]    dbg_nw;

  int checks = 0;
  int errors = 0;

  // Reference model: head at index 0, snake direction and life state.
  int mx[$];
  int my[$];
  int m_len;
  int m_dir;
  bit m_dead;

  always #5 clk = ~clk;

  snake_body_engine #(
    .MAX_LEN(ML), .INIT_LEN(IL), .X_BITS(8), .Y_BITS(7),
    .GRID_W(GW), .GRID_H(GH), .WRAP_MODE(1)
  ) u_dut (
    .CLK(clk), .RESET(rst), .GAMECLOCK(tick), .MASTER_STATE(ms),
    .NAVIGATION_STATE(nav), .RAND_ADDRH(th), .RAND_ADDRV(tv),
    .PIX_ADDRH(ph), .PIX_ADDRV(pv), .PIX_BODY(body), .PIX_HEAD(head),
    .REACHED_TARGET(reached), .SUICIDE(suicide), .LENGTH(len), .DEBUG_OUT(dbg)
  );

  snake_body_engine #(
    .MAX_LEN(ML), .INIT_LEN(IL), .X_BITS(8), .Y_BITS(7),
    .GRID_W(GW), .GRID_H(GH), .WRAP_MODE(0)
  ) u_dut_nw (
    .CLK(clk), .RESET(rst), .GAMECLOCK(tick), .MASTER_STATE(ms),
    .NAVIGATION_STATE(nav), .RAND_ADDRH(th), .RAND_ADDRV(tv),
    .PIX_ADDRH(ph), .PIX_ADDRV(pv), .PIX_BODY(body_nw), .PIX_HEAD(head_nw),
    .REACHED_TARGET(reached_nw), .SUICIDE(suicide_nw), .LENGTH(len_nw), .DEBUG_OUT(dbg_nw)
  );

  function automatic void m_restart();
    mx.delete();
    my.delete();
    for (int i = 0; i < IL; i++) begin
      mx.push_back(GW / 2 - i);
      my.push_back(GH / 2);
    end
    m_len  = IL;
    m_dir  = 1;
    m_dead = 0;
  endfunction

  function automatic int m_accept(input int n);
    return ((n + 2) % 4 == m_dir) ? m_dir : n;
  endfunction

  function automatic void m_next(input int d, output int nx, output int ny);
    nx = mx[0];
    ny = my[0];
    case (d)
      0:       ny = ny - 1;
      1:       nx = nx + 1;
      2:       ny = ny + 1;
      default: nx = nx - 1;
    endcase
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
  endfunction

  function automatic bit m_tick(input int n, input int tx, input int ty);
    int nx, ny;
    bit eat;
    eat = 0;
    if (m_dead) return 0;
    m_dir = m_accept(n);
    m_next(m_dir, nx, ny);
    mx.push_front(nx);
    my.push_front(ny);
    if (mx.size() > ML) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    if (nx == tx && ny == ty) begin
      eat = 1;
      if (m_len < ML) m_len++;
    end
    for (int i = 1; i < m_len; i++)
      if (mx[i] == nx && my[i] == ny) m_dead = 1;
    return eat;
  endfunction

  function automatic bit m_body(input int x, input int y);
    for (int i = 0; i < m_len; i++)
      if (mx[i] == x && my[i] == y) return 1;
    return 0;
  endfunction

  task automatic restart();
    @(negedge clk);
    ms = 2'd0;
    repeat (2) @(negedge clk);
    ms = 2'd1;
    repeat (2) @(negedge clk);
    m_restart();
  endtask

  task automatic do_tick(input int n, input int tx, input int ty, output logic r1, output logic r2);
    @(negedge clk);
    nav  = 2'(n);
    th   = 8'(tx);
    tv   = 7'(ty);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    r1   = reached;
    @(negedge clk);
    r2   = reached;
  endtask

  task automatic settle();
    repeat (ML + 4) @(negedge clk);
  endtask

  task automatic query(input int x, input int y);
    @(negedge clk);
    ph = 8'(x);
    pv = 7'(y);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ms = 2'd0; tick = 1'b0; nav = 2'd1;
    th = 8'd0; tv = 7'd0; ph = 8'd80; pv = 7'd60;
    repeat (3) @(negedge clk);
    checks++;
    if (len !== LW'(IL)) begin errors++; $display("FAIL reset_len: got %0d expected %0d", len, IL); end
    checks++;
    if ({body, head, reached, suicide} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {body, head, reached, suicide});
    end
    checks++;
    if (dbg !== 8'h00 || dbg_nw !== 8'h00 || reached_nw !== 1'b0) begin
      errors++; $display("FAIL reset_debug: got %h/%h expected 00", dbg, dbg_nw);
    end
    @(negedge clk);
    rst = 1'b0;
    m_restart();
    query(80, 60);
    checks++;
    if ({body, head} !== 2'b11) begin errors++; $display("FAIL reset_head_query: got %b expected 11", {body, head}); end
    query(77, 60);
    checks++;
    if ({body, head} !== 2'b10) begin errors++; $display("FAIL reset_tail_query: got %b expected 10", {body, head}); end
  endtask

  task automatic test_move();
    logic r1, r2;
    bit   eat;
    restart();
    for (int t = 0; t < 3; t++) begin
      eat = m_tick(1, 10, 10);
      do_tick(1, 10, 10, r1, r2);
      settle();
      checks++;
      if (r1 !== eat) begin errors++; $display("FAIL move_reached: got %b expected %b", r1, eat); end
    end
    query(mx[0], my[0]);
    checks++;
    if ({body, head} !== 2'b11 || mx[0] != 83) begin
      errors++; $display("FAIL move_head: got %b expected 11 at (%0d,%0d)", {body, head}, mx[0], my[0]);
    end
    checks++;
    if (len !== LW'(m_len) || suicide !== m_dead) begin
      errors++; $display("FAIL move_state: got len %0d suicide %b expected %0d %b", len, suicide, m_len, m_dead);
    end
    query(79, 60);
    checks++;
    if ({body, head} !== {m_body(79, 60), 1'b0}) begin
      errors++; $display("FAIL move_stale_seg: got %b expected 00", {body, head});
    end
  endtask

  task automatic test_target();
    logic r1, r2;
    bit   eat;
    restart();
    eat = m_tick(1, 81, 60);
    do_tick(1, 81, 60, r1, r2);
    checks++;
    if (r1 !== eat || r2 !== 1'b0) begin
      errors++; $display("FAIL target_pulse: got %b%b expected %b0", r1, r2, eat);
    end
    settle();
    checks++;
    if (len !== LW'(m_len)) begin errors++; $display("FAIL target_len: got %0d expected %0d", len, m_len); end
    query(77, 60);
    checks++;
    if (body !== m_body(77, 60)) begin errors++; $display("FAIL target_tail_kept: got %b expected %b", body, m_body(77, 60)); end
  endtask

  task automatic test_reversal();
    logic r1, r2;
    bit   eat;
    eat = m_tick(3, 10, 10);
    do_tick(3, 10, 10, r1, r2);
    settle();
    query(mx[0], my[0]);
    checks++;
    if (head !== 1'b1 || mx[0] != 82) begin
      errors++; $display("FAIL reversal_head: got %b expected 1 at (%0d,%0d)", head, mx[0], my[0]);
    end
  endtask

  task automatic test_wrap();
    logic r1, r2;
    bit   eat;
    restart();
    for (int t = 0; t < 79; t++) begin
      eat = m_tick(1, 5, 5);
      do_tick(1, 5, 5, r1, r2);
      settle();
    end
    query(159, 60);
    checks++;
    if ({head, head_nw} !== 2'b11) begin errors++; $display("FAIL wrap_edge_head: got %b expected 11", {head, head_nw}); end
    eat = m_tick(1, 5, 5);
    do_tick(1, 5, 5, r1, r2);
    settle();
    query(mx[0], my[0]);
    checks++;
    if (head !== 1'b1 || mx[0] != 0) begin errors++; $display("FAIL wrap_head: got %b expected 1 at x=%0d", head, mx[0]); end
    checks++;
    if (suicide !== 1'b0 || suicide_nw !== 1'b1) begin
      errors++; $display("FAIL wall_suicide: got wrap %b wall %b expected 0 1", suicide, suicide_nw);
    end
    query(159, 60);
    checks++;
    if ({body_nw, head_nw} !== 2'b11 || len_nw !== LW'(IL)) begin
      errors++; $display("FAIL wall_frozen: got %b len %0d expected 11 len %0d", {body_nw, head_nw}, len_nw, IL);
    end
  endtask

  task automatic test_collision();
    logic r1, r2;
    bit   eat;
    restart();
    eat = m_tick(1, 81, 60);
    do_tick(1, 81, 60, r1, r2);
    settle();
    eat = m_tick(0, 10, 10);
    do_tick(0, 10, 10, r1, r2);
    settle();
    eat = m_tick(3, 10, 10);
    do_tick(3, 10, 10, r1, r2);
    settle();
    checks++;
    if (suicide !== 1'b0 || len !== LW'(5)) begin
      errors++; $display("FAIL collision_pre: got suicide %b len %0d expected 0 5", suicide, len);
    end
    eat = m_tick(2, 10, 10);
    do_tick(2, 10, 10, r1, r2);
    repeat (m_len - 2) @(negedge clk);
    checks++;
    if (suicide !== m_dead) begin errors++; $display("FAIL collision_latency: got %b expected %b", suicide, m_dead); end
    @(negedge clk);
    ms = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (suicide !== 1'b0 || len !== LW'(IL)) begin
      errors++; $display("FAIL collision_restart: got suicide %b len %0d expected 0 %0d", suicide, len, IL);
    end
  endtask

  task automatic test_freeze();
    logic r1, r2;
    bit   eat;
    restart();
    @(negedge clk);
    ms = 2'd2;
    do_tick(1, 10, 10, r1, r2);
    settle();
    query(80, 60);
    checks++;
    if (head !== 1'b1) begin errors++; $display("FAIL freeze_head: got %b expected 1", head); end
    ms = 2'd1;
    repeat (2) @(negedge clk);
    eat = m_tick(1, 10, 10);
    do_tick(1, 10, 10, r1, r2);
    settle();
    query(mx[0], my[0]);
    checks++;
    if (head !== 1'b1) begin errors++; $display("FAIL resume_head: got %b expected 1", head); end
  endtask

  task automatic test_reset_mid_scan();
    logic r1, r2;
    bit   eat;
    restart();
    eat = m_tick(1, 81, 60);
    do_tick(1, 81, 60, r1, r2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_restart();
    checks++;
    if (len !== LW'(IL) || suicide !== 1'b0) begin
      errors++; $display("FAIL midscan_reset: got len %0d suicide %b expected %0d 0", len, suicide, IL);
    end
    query(81, 60);
    checks++;
    if ({body, head} !== 2'b00) begin errors++; $display("FAIL midscan_old_head: got %b expected 00", {body, head}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic r1, r2;
    bit   eat;
    int   n, d, px, py, tx, ty, qx, qy, k;
    restart();
    for (int t = 0; t < 60; t++) begin
      n = int'($urandom_range(0, 3));
      d = m_accept(n);
      m_next(d, px, py);
      if ($urandom_range(0, 2) == 0) begin
        tx = px; ty = py;
      end else begin
        tx = int'($urandom_range(0, GW - 1)); ty = int'($urandom_range(0, GH - 1));
      end
      eat = m_tick(n, tx, ty);
      do_tick(n, tx, ty, r1, r2);
      settle();
      checks++;
      if (r1 !== eat || r2 !== 1'b0) begin errors++; $display("FAIL rand_reached: got %b%b expected %b0", r1, r2, eat); end
      checks++;
      if (len !== LW'(m_len) || suicide !== m_dead) begin
        errors++; $display("FAIL rand_state: got len %0d suicide %b expected %0d %b", len, suicide, m_len, m_dead);
      end
      query(mx[0], my[0]);
      checks++;
      if ({body, head} !== 2'b11) begin errors++; $display("FAIL rand_head: got %b expected 11", {body, head}); end
      k = int'($urandom_range(0, mx.size() - 1));
      qx = mx[k]; qy = my[k];
      if ($urandom_range(0, 3) == 0) begin qx = int'($urandom_range(0, GW - 1)); qy = int'($urandom_range(0, GH - 1)); end
      query(qx, qy);
      checks++;
      if (body !== m_body(qx, qy) || head !== (qx == mx[0] && qy == my[0])) begin
        errors++; $display("FAIL rand_query: (%0d,%0d) got %b%b expected %b%b", qx, qy, body, head,
                           m_body(qx, qy), (qx == mx[0] && qy == my[0]));
      end
      if (m_dead) restart();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_move();
    test_target();
    test_reversal();
    test_wrap();
    test_collision();
    test_freeze();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
